// File: rtl/isdu_pkg.sv
// -----------------------------------------------------------------------------
// isdu_pkg
// Shared definitions for the parametrised SLC-3 control unit (isdu_param):
//   - state_e     : FSM state encoding
//   - PCMUX_*     : PC source select encodings
//   - ADDR2MUX_*  : address adder operand-2 encodings
//   - ALUK_*      : ALU function encodings
//   - DRMUX_*     : destination register select encodings
//   - OP_*        : IR[15:12] opcode constants
//   - is_counted(): true for states that hold the memory strobes for a counted
//                   number of cycles
// -----------------------------------------------------------------------------
package isdu_pkg;

  typedef enum logic [4:0] {
    S_HALTED    = 5'd0,
    S_FETCH_MAR = 5'd1,
    S_FETCH_RD  = 5'd2,
    S_FETCH_IR  = 5'd3,
    S_DECODE    = 5'd4,
    S_ALU_ADD   = 5'd5,
    S_ALU_AND   = 5'd6,
    S_ALU_NOT   = 5'd7,
    S_BR_CHK    = 5'd8,
    S_BR_TAKE   = 5'd9,
    S_JMP       = 5'd10,
    S_JSR_SAVE  = 5'd11,
    S_JSR       = 5'd12,
    S_JSRR      = 5'd13,
    S_LEA       = 5'd14,
    S_LDR_ADDR  = 5'd15,
    S_LD_RD     = 5'd16,
    S_LD_WB     = 5'd17,
    S_STR_ADDR  = 5'd18,
    S_ST_MDR    = 5'd19,
    S_ST_WR     = 5'd20,
    S_DONE      = 5'd21,
    S_PAUSE1    = 5'd22,
    S_PAUSE2    = 5'd23
  } state_e;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2MUX_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2MUX_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2MUX_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2MUX_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic DRMUX_IR = 1'b0;
  localparam logic DRMUX_R7 = 1'b1;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // States that run the shared wait counter.
  function automatic logic is_counted(input state_e s);
    return (s == S_FETCH_RD) || (s == S_LD_RD) || (s == S_ST_WR);
  endfunction

endpackage

// File: rtl/isdu_wait_ctr.sv
// -----------------------------------------------------------------------------
// isdu_wait_ctr
// Memory-access wait counter shared by every counted state of isdu_param.
//   Clk, Reset : clock, synchronous active-high reset
//   clr_i      : clear the count (asserted in the cycle the counted state exits)
//   en_i       : a counted state is active; count advances
//   done_o     : minimum access length reached (count == MEM_WAIT-1)
// The count saturates at MEM_WAIT-1 so it can never wrap while the FSM waits
// for an external ready.
// -----------------------------------------------------------------------------
module isdu_wait_ctr #(
  parameter int MEM_WAIT = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = en_i && (count_q == LAST);

endmodule

// File: rtl/isdu_param.sv
// -----------------------------------------------------------------------------
// isdu_param
// Parametrised SLC-3 instruction sequencer / decode unit (Moore FSM).
// Sequences fetch, decode and execute, driving datapath loads, bus gates,
// mux selects and the SRAM strobes.
//
// Parameters:
//   MEM_WAIT     : cycles Mem_OE / Mem_WE are held per access (1..15)
//   STEP_DEFAULT : reset value of the step-mode flag
// Optional build macro:
//   ISDU_MEMRDY_EN : counted states additionally wait for Mem_Rdy=1; the count
//                    becomes a minimum length. Undefined: Mem_Rdy is ignored.
//
// Ports:
//   Clk, Reset                 : clock, synchronous active-high reset
//   Run, Continue, Step        : start / pause release / step-mode request
//   Opcode, IR_5, IR_11, BEN   : instruction fields and branch enable
//   Mem_Rdy                    : SRAM ready (optional feature only)
//   LD_*                       : register load enables
//   Gate*                      : bus drivers
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK : datapath selects
//   Mem_OE, Mem_WE             : SRAM strobes
//   Busy                       : high in every state except HALTED
// -----------------------------------------------------------------------------
module isdu_param
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT     = 3,
  parameter bit STEP_DEFAULT = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic       Step,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       Mem_Rdy,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Busy
);

  state_e state_q, state_d;
  logic   step_q, step_d;
  logic   wait_en;
  logic   wait_done;
  logic   wait_exit;

  assign wait_en = is_counted(state_q);

  // The counted state leaves (and the counter clears) on wait_exit.
`ifdef ISDU_MEMRDY_EN
  assign wait_exit = wait_done && Mem_Rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = Mem_Rdy;
  assign wait_exit      = wait_done;
`endif

  isdu_wait_ctr #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait_ctr (
    .Clk   (Clk),
    .Reset (Reset),
    .clr_i (wait_exit),
    .en_i  (wait_en),
    .done_o(wait_done)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_HALTED;
      step_q  <= STEP_DEFAULT;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      S_HALTED: begin
        if (Run) begin
          state_d = S_FETCH_MAR;
          step_d  = Step;
        end
      end
      S_FETCH_MAR: state_d = S_FETCH_RD;
      S_FETCH_RD:  if (wait_exit) state_d = S_FETCH_IR;
      S_FETCH_IR:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD:  state_d = S_ALU_ADD;
          OP_AND:  state_d = S_ALU_AND;
          OP_NOT:  state_d = S_ALU_NOT;
          OP_BR:   state_d = S_BR_CHK;
          OP_JMP:  state_d = S_JMP;
          OP_JSR:  state_d = S_JSR_SAVE;
          OP_LEA:  state_d = S_LEA;
          OP_LDR:  state_d = S_LDR_ADDR;
          OP_STR:  state_d = S_STR_ADDR;
          OP_PSE:  state_d = S_PAUSE1;
          default: state_d = S_FETCH_MAR;  // unimplemented opcodes act as NOP
        endcase
      end
      S_ALU_ADD, S_ALU_AND, S_ALU_NOT: state_d = S_DONE;
      S_BR_CHK:   state_d = BEN ? S_BR_TAKE : S_DONE;
      S_BR_TAKE:  state_d = S_DONE;
      S_JMP:      state_d = S_DONE;
      S_JSR_SAVE: state_d = IR_11 ? S_JSR : S_JSRR;
      S_JSR, S_JSRR: state_d = S_DONE;
      S_LEA:      state_d = S_DONE;
      S_LDR_ADDR: state_d = S_LD_RD;
      S_LD_RD:    if (wait_exit) state_d = S_LD_WB;
      S_LD_WB:    state_d = S_DONE;
      S_STR_ADDR: state_d = S_ST_MDR;
      S_ST_MDR:   state_d = S_ST_WR;
      S_ST_WR:    if (wait_exit) state_d = S_DONE;
      S_DONE:     state_d = step_q ? S_PAUSE1 : S_FETCH_MAR;
      S_PAUSE1:   if (Continue) state_d = S_PAUSE2;
      S_PAUSE2:   if (!Continue) state_d = S_FETCH_MAR;
      default:    state_d = S_HALTED;
    endcase
  end

  // Output decode: everything defaults low, each state raises its own set.
  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_PC1;
    DRMUX      = DRMUX_IR;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2MUX_ZERO;
    ALUK       = ALUK_ADD;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    Busy       = (state_q != S_HALTED);
    unique case (state_q)
      S_FETCH_MAR: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
        PCMUX  = PCMUX_PC1;
      end
      S_FETCH_RD, S_LD_RD: begin
        Mem_OE = 1'b1;
        LD_MDR = wait_exit;  // capture data only in the final read cycle
      end
      S_FETCH_IR: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_DECODE: LD_BEN = 1'b1;
      S_ALU_ADD, S_ALU_AND, S_ALU_NOT: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        ALUK    = (state_q == S_ALU_AND) ? ALUK_AND :
                  (state_q == S_ALU_NOT) ? ALUK_NOT : ALUK_ADD;
      end
      S_BR_TAKE: begin
        ADDR2MUX = ADDR2MUX_OFF9;
        PCMUX    = PCMUX_ADDR;
        LD_PC    = 1'b1;
      end
      S_JMP: begin
        SR1MUX  = 1'b1;
        ALUK    = ALUK_PASSA;
        GateALU = 1'b1;
        PCMUX   = PCMUX_BUS;
        LD_PC   = 1'b1;
      end
      S_JSR_SAVE: begin
        GatePC = 1'b1;
        DRMUX  = DRMUX_R7;
        LD_REG = 1'b1;
      end
      S_JSR: begin
        ADDR2MUX = ADDR2MUX_OFF11;
        PCMUX    = PCMUX_ADDR;
        LD_PC    = 1'b1;
      end
      S_JSRR: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        ADDR2MUX = ADDR2MUX_ZERO;
        PCMUX    = PCMUX_ADDR;
        LD_PC    = 1'b1;
      end
      S_LEA: begin
        ADDR2MUX   = ADDR2MUX_OFF9;
        GateMARMUX = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
      end
      S_LDR_ADDR, S_STR_ADDR: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2MUX_OFF6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_LD_WB: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_ST_MDR: begin
        SR1MUX  = 1'b0;
        ALUK    = ALUK_PASSA;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_ST_WR: Mem_WE = 1'b1;
      S_PAUSE1, S_PAUSE2: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu_param.sv
// Directed bench: three instances (MEM_WAIT = 3, 1, 4) share the stimulus;
// each test resets, launches one instruction and compares the selected
// instance's packed output word cycle by cycle against hand-built constants.
module tb_isdu_param;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       Continue = 1'b0;
  logic       Step = 1'b0;
  logic [3:0] Opcode = 4'b0000;
  logic       IR_5 = 1'b0;
  logic       IR_11 = 1'b0;
  logic       BEN = 1'b0;
  logic       Mem_Rdy = 1'b1;

  always #5 Clk = ~Clk;

  logic [2:0] ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
  logic [2:0] gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [2:0] drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we, busy;
  logic [1:0] pcmux [3];
  logic [1:0] addr2mux [3];
  logic [1:0] aluk [3];
  logic [24:0] sig [3];

  // Output word bit positions
  localparam logic [24:0] B_LD_MAR   = 25'd1 << 24;
  localparam logic [24:0] B_LD_MDR   = 25'd1 << 23;
  localparam logic [24:0] B_LD_IR    = 25'd1 << 22;
  localparam logic [24:0] B_LD_BEN   = 25'd1 << 21;
  localparam logic [24:0] B_LD_CC    = 25'd1 << 20;
  localparam logic [24:0] B_LD_REG   = 25'd1 << 19;
  localparam logic [24:0] B_LD_PC    = 25'd1 << 18;
  localparam logic [24:0] B_LD_LED   = 25'd1 << 17;
  localparam logic [24:0] B_GATEPC   = 25'd1 << 16;
  localparam logic [24:0] B_GATEMDR  = 25'd1 << 15;
  localparam logic [24:0] B_GATEALU  = 25'd1 << 14;
  localparam logic [24:0] B_GATEMARM = 25'd1 << 13;
  localparam logic [24:0] B_PCM_BUS  = 25'd1 << 11;
  localparam logic [24:0] B_PCM_ADDR = 25'd2 << 11;
  localparam logic [24:0] B_DRMUX    = 25'd1 << 10;
  localparam logic [24:0] B_SR1MUX   = 25'd1 << 9;
  localparam logic [24:0] B_SR2MUX   = 25'd1 << 8;
  localparam logic [24:0] B_ADDR1MUX = 25'd1 << 7;
  localparam logic [24:0] B_A2_OFF6  = 25'd1 << 5;
  localparam logic [24:0] B_A2_OFF9  = 25'd2 << 5;
  localparam logic [24:0] B_A2_OFF11 = 25'd3 << 5;
  localparam logic [24:0] B_ALUK_NOT = 25'd2 << 3;
  localparam logic [24:0] B_ALUK_PA  = 25'd3 << 3;
  localparam logic [24:0] B_MEM_OE   = 25'd1 << 2;
  localparam logic [24:0] B_MEM_WE   = 25'd1 << 1;
  localparam logic [24:0] B_BUSY     = 25'd1;

  // Frequently used state signatures
  localparam logic [24:0] E_FMAR  = B_GATEPC | B_LD_MAR | B_LD_PC | B_BUSY;
  localparam logic [24:0] E_RD    = B_MEM_OE | B_BUSY;
  localparam logic [24:0] E_RDL   = B_MEM_OE | B_LD_MDR | B_BUSY;
  localparam logic [24:0] E_FIR   = B_GATEMDR | B_LD_IR | B_BUSY;
  localparam logic [24:0] E_DEC   = B_LD_BEN | B_BUSY;
  localparam logic [24:0] E_DONE  = B_BUSY;
  localparam logic [24:0] E_MADDR = B_SR1MUX | B_ADDR1MUX | B_A2_OFF6 | B_GATEMARM | B_LD_MAR | B_BUSY;
  localparam logic [24:0] E_LED   = B_LD_LED | B_BUSY;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    isdu_param #(
      .MEM_WAIT((gi == 0) ? 3 : (gi == 1) ? 1 : 4),
      .STEP_DEFAULT(1'b0)
    ) u_dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Step(Step),
      .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Mem_Rdy(Mem_Rdy),
      .LD_MAR(ld_mar[gi]), .LD_MDR(ld_mdr[gi]), .LD_IR(ld_ir[gi]), .LD_BEN(ld_ben[gi]),
      .LD_CC(ld_cc[gi]), .LD_REG(ld_reg[gi]), .LD_PC(ld_pc[gi]), .LD_LED(ld_led[gi]),
      .GatePC(gate_pc[gi]), .GateMDR(gate_mdr[gi]), .GateALU(gate_alu[gi]),
      .GateMARMUX(gate_marmux[gi]), .PCMUX(pcmux[gi]), .DRMUX(drmux[gi]),
      .SR1MUX(sr1mux[gi]), .SR2MUX(sr2mux[gi]), .ADDR1MUX(addr1mux[gi]),
      .ADDR2MUX(addr2mux[gi]), .ALUK(aluk[gi]), .Mem_OE(mem_oe[gi]),
      .Mem_WE(mem_we[gi]), .Busy(busy[gi])
    );
    assign sig[gi] = {ld_mar[gi], ld_mdr[gi], ld_ir[gi], ld_ben[gi], ld_cc[gi],
                      ld_reg[gi], ld_pc[gi], ld_led[gi], gate_pc[gi], gate_mdr[gi],
                      gate_alu[gi], gate_marmux[gi], pcmux[gi], drmux[gi], sr1mux[gi],
                      sr2mux[gi], addr1mux[gi], addr2mux[gi], aluk[gi], mem_oe[gi],
                      mem_we[gi], busy[gi]};
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [24:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Run = 1'b0;
    Continue = 1'b0;
    Step = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Advance one cycle per queued word and compare instance 'inst' to it.
  task automatic expect_seq(input int inst, input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      if (i == 0) Run = 1'b0;
      check($sformatf("%s[%0d]", tag, i), {7'd0, sig[inst]}, {7'd0, exp_q[i]});
    end
    $display("txn %s: %0d cycles compared on instance %0d", tag, exp_q.size(), inst);
  endtask

  initial begin
    // Reset state of all three instances
    do_reset();
    for (int k = 0; k < 3; k++) check($sformatf("reset_out%0d", k), {7'd0, sig[k]}, 32'd0);

    // ADD R1,R1,#1 with MEM_WAIT=3
    do_reset();
    Opcode = 4'b0001; IR_5 = 1'b1; Run = 1'b1;
    exp_q = '{E_FMAR, E_RD, E_RD, E_RDL, E_FIR, E_DEC,
              B_SR1MUX | B_SR2MUX | B_GATEALU | B_LD_REG | B_LD_CC | B_BUSY,
              E_DONE, E_FMAR};
    expect_seq(0, "add_w3");

    // LDR with MEM_WAIT=1
    do_reset();
    Opcode = 4'b0110; IR_5 = 1'b0; Run = 1'b1;
    exp_q = '{E_FMAR, E_RDL, E_FIR, E_DEC, E_MADDR, E_RDL,
              B_GATEMDR | B_LD_REG | B_LD_CC | B_BUSY, E_DONE, E_FMAR};
    expect_seq(1, "ldr_w1");

    // STR with MEM_WAIT=4
    do_reset();
    Opcode = 4'b0111; Run = 1'b1;
    exp_q = '{E_FMAR, E_RD, E_RD, E_RD, E_RDL, E_FIR, E_DEC, E_MADDR,
              B_ALUK_PA | B_GATEALU | B_LD_MDR | B_BUSY,
              B_MEM_WE | B_BUSY, B_MEM_WE | B_BUSY, B_MEM_WE | B_BUSY, B_MEM_WE | B_BUSY,
              E_DONE, E_FMAR};
    expect_seq(2, "str_w4");

    // BR not taken
    do_reset();
    Opcode = 4'b0000; BEN = 1'b0; Run = 1'b1;
    exp_q = '{E_FMAR, E_RD, E_RD, E_RDL, E_FIR, E_DEC, B_BUSY, E_DONE, E_FMAR};
    expect_seq(0, "br_nt");

    // BR taken
    do_reset();
    BEN = 1'b1; Run = 1'b1;
    exp_q = '{E_FMAR, E_RDL, E_FIR, E_DEC, B_BUSY,
              B_A2_OFF9 | B_PCM_ADDR | B_LD_PC | B_BUSY, E_DONE, E_FMAR};
    expect_seq(1, "br_tk");
    BEN = 1'b0;

    // JSRR (IR_11=0)
    do_reset();
    Opcode = 4'b0100; IR_11 = 1'b0; Run = 1'b1;
    exp_q = '{E_FMAR, E_RDL, E_FIR, E_DEC,
              B_GATEPC | B_DRMUX | B_LD_REG | B_BUSY,
              B_SR1MUX | B_ADDR1MUX | B_PCM_ADDR | B_LD_PC | B_BUSY, E_DONE};
    expect_seq(1, "jsrr");

    // JSR (IR_11=1)
    do_reset();
    IR_11 = 1'b1; Run = 1'b1;
    exp_q = '{E_FMAR, E_RDL, E_FIR, E_DEC,
              B_GATEPC | B_DRMUX | B_LD_REG | B_BUSY,
              B_A2_OFF11 | B_PCM_ADDR | B_LD_PC | B_BUSY, E_DONE};
    expect_seq(1, "jsr");

    // LEA and JMP
    do_reset();
    Opcode = 4'b1110; Run = 1'b1;
    exp_q = '{E_FMAR, E_RDL, E_FIR, E_DEC,
              B_A2_OFF9 | B_GATEMARM | B_LD_REG | B_LD_CC | B_BUSY, E_DONE};
    expect_seq(1, "lea");
    do_reset();
    Opcode = 4'b1100; Run = 1'b1;
    exp_q = '{E_FMAR, E_RDL, E_FIR, E_DEC,
              B_SR1MUX | B_ALUK_PA | B_GATEALU | B_PCM_BUS | B_LD_PC | B_BUSY, E_DONE};
    expect_seq(1, "jmp");

    // Unused opcode behaves as NOP
    do_reset();
    Opcode = 4'b1010; Run = 1'b1;
    exp_q = '{E_FMAR, E_RDL, E_FIR, E_DEC, E_FMAR};
    expect_seq(1, "nop");

    // Step mode with NOT, then Continue handshake
    do_reset();
    Opcode = 4'b1001; IR_5 = 1'b0; Step = 1'b1; Run = 1'b1;
    exp_q = '{E_FMAR, E_RDL, E_FIR, E_DEC,
              B_SR1MUX | B_ALUK_NOT | B_GATEALU | B_LD_REG | B_LD_CC | B_BUSY,
              E_DONE, E_LED, E_LED};
    expect_seq(1, "step_not");
    Step = 1'b0;
    Continue = 1'b1;
    tick(); check("pause2_enter", {7'd0, sig[1]}, {7'd0, E_LED});
    tick(); check("pause2_hold", {7'd0, sig[1]}, {7'd0, E_LED});
    Continue = 1'b0;
    tick(); check("pause_release", {7'd0, sig[1]}, {7'd0, E_FMAR});
    $display("txn step_release: continue handshake on instance 1");

    // Reset during the 2nd FETCH_RD cycle, then a clean fetch
    do_reset();
    Opcode = 4'b0001; IR_5 = 1'b1; Run = 1'b1;
    exp_q = '{E_FMAR, E_RD, E_RD};
    expect_seq(0, "rst_mid_pre");
    Reset = 1'b1;
    tick(); check("rst_mid_out", {7'd0, sig[0]}, 32'd0);
    check("rst_mid_busy", {29'd0, busy}, 32'd0);
    Reset = 1'b0; Run = 1'b1;
    exp_q = '{E_FMAR, E_RD, E_RD, E_RDL, E_FIR};
    expect_seq(0, "rst_mid_post");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
